mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Parametrised successor of the single-cycle MEM stage. Memory accesses go through an external request/acknowledge port with wait states, so stores can be byte, half or word wide and loads can be sign- or zero-extended.
- The block stalls the upstream pipeline while an access is outstanding and flags misaligned or timed-out accesses.
- It contains the MEM/WB pipeline register and sits between EX/MEM and the writeback stage.

Parameters:
- DATA_W, 32, datapath width; must be a multiple of 32.
- ADDR_W, 16, word-address width driven on mem_addr.
- TIMEOUT, 15, maximum cycles spent in BUSY before an access is abandoned; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- RegWrite_EX  in  1  instruction writes the register file
- memW  in  1  store
- memR  in  1  load
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned  in  1  zero-extend loads when 1
- WBdata  in  2  writeback select: 00 ALU, 01 memory, 10 NPC3
- D  in  DATA_W  store data
- ALUout  in  DATA_W  byte address / ALU result
- NPC3  in  DATA_W  link value
- rd3  in  5  destination register
- stall_out  out  1  upstream must hold its inputs
- mem_req  out  1  access request
- mem_we  out  1  write strobe
- mem_be  out  DATA_W/8  byte enables
- mem_addr  out  ADDR_W  word address = ALUout[ADDR_W+1:2]
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  access complete
- RegWrite_MEM  out  1  registered write enable
- Rd3_MEM  out  5  registered destination
- WBdata_out  out  DATA_W  registered writeback value
- wb_valid  out  1  MEM/WB slot holds a real instruction
- misalign_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset low, asynchronous): state IDLE, timeout counter 0, all registered outputs 0. Memory-port outputs are 0 because they are driven from registered state.
- Non-memory op (in_valid, !memR, !memW) in IDLE: one-cycle latency. The MEM/WB register loads next edge with RegWrite_EX, rd3, and WBdata mux output (ALUout or NPC3; 01 or 11 gives 0). wb_valid=1.
- !in_valid in IDLE: bubble. wb_valid=0, RegWrite_MEM=0.
- Misalignment: half needs addr[0]=0; word needs addr[1:0]=00.
- Misaligned memory op: no request is issued. Next edge: wb_valid=1, RegWrite_MEM=0, misalign_err=1 for one cycle. No stall.
- Aligned memory op in IDLE:
  - stall_out=1 combinationally.
  - Next edge: latch op fields and enter BUSY with counter=0; the MEM/WB slot becomes a bubble.
- BUSY:
  - mem_req=1; mem_we=latched memW.
  - mem_be: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
  - mem_wdata: byte {4{D[7:0]}}, half {2{D[15:0]}}, word D.
  - stall_out = !mem_ack.
- mem_ack in BUSY:
  - Same edge: MEM/WB loads, wb_valid=1, state returns to IDLE.
  - Loads: the lane selected by a[1:0] is extended per mem_unsigned.
  - Stores: RegWrite_MEM is forced 0.
  - stall_out drops in the ack cycle, so the next instruction is accepted on the following edge.
- Timeout: if the counter reaches TIMEOUT without mem_ack:
  - Return to IDLE, bus_err=1 for one cycle.
  - wb_valid=1 with RegWrite_MEM=0.
  - stall_out drops in that cycle.
- mem_ack while in IDLE is ignored.
- mem_ack in the same cycle as timeout: ack wins, no bus_err.
- Reset asserted mid-BUSY: immediate return to IDLE, mem_req=0, the access is abandoned.
- For DATA_W>32: the low 32 bits carry the lane logic; upper byte enables are 0 for sub-word accesses and 1 for word accesses.

Decomposition:
- Shared package mem_pkg:
  - WB_ALU/WB_MEM/WB_NPC constants.
  - SIZE_B/SIZE_H/SIZE_W constants.
  - State enum IDLE/BUSY.
- Sub-module mem_lane_align: purely combinational. Produces mem_be and mem_wdata from size, offset and D, and the extended load data from size, offset, unsigned and mem_rdata.

Test Plan:
- ALU op, ALUout=0x1234, WBdata=00, rd3=5, RegWrite_EX=1 -> next cycle WBdata_out=0x1234, Rd3_MEM=5, RegWrite_MEM=1, wb_valid=1, stall_out never high.
- Signed byte load at addr 0x0003, mem_rdata=0x80FFFF00 with ack after 3 wait cycles -> stall_out high 4 cycles, mem_be=1000, WBdata_out=0xFFFFFF80; same load with mem_unsigned=1 -> 0x00000080.
- Half store D=0x0000ABCD at addr 0x0002, immediate ack -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, RegWrite_MEM=0, wb_valid=1.
- Word load at addr 0x0006 -> no mem_req, misalign_err pulses once, RegWrite_MEM=0, no stall.
- Load with no ack, TIMEOUT=15 -> mem_req high 16 cycles, then bus_err pulse, state IDLE, next ALU op completes normally.
- Reset pulled low during BUSY -> mem_req, stall_out and all registered outputs 0 immediately; after release, a new access proceeds normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: writeback selects, access sizes, FSM states
// and the alignment rule used to reject misaligned accesses.
package mem_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_NPC = 2'b10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The reserved size encoding behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            default: bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory port: byte enables and replicated store data
// on the way out, lane extraction plus sign/zero extension on the way back.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          size,
    input  logic [1:0]          offset,
    input  logic                is_unsigned,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   load_raw,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   load_ext
);

    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_pos  = {offset, 3'b000};
    assign half_pos  = {offset[1], 4'b0000};
    assign byte_lane = load_raw[byte_pos +: 8];
    assign half_lane = load_raw[half_pos +: 16];

    // Lane logic lives in the low 32 bits; wider buses only use the upper lanes on word accesses.
    always_comb begin
        be    = '0;
        wdata = store_data;
        case (size)
            SIZE_B: begin
                be[3:0]     = 4'b0001 << offset;
                wdata[31:0] = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                be[3:0]     = 4'b0011 << offset;
                wdata[31:0] = {2{store_data[15:0]}};
            end
            default: be = '1;
        endcase
    end

    always_comb begin
        case (size)
            SIZE_B:  load_ext = {{(DATA_W-8){byte_lane[7] & ~is_unsigned}}, byte_lane};
            SIZE_H:  load_ext = {{(DATA_W-16){half_lane[15] & ~is_unsigned}}, half_lane};
            default: load_ext = load_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage with a request/acknowledge memory port: stalls upstream during wait states,
// flags misaligned and timed-out accesses, and holds the MEM/WB pipeline register.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                RegWrite_EX,
    input  logic                memW,
    input  logic                memR,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [1:0]          WBdata,
    input  logic [DATA_W-1:0]   D,
    input  logic [DATA_W-1:0]   ALUout,
    input  logic [DATA_W-1:0]   NPC3,
    input  logic [4:0]          rd3,
    output logic                stall_out,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                RegWrite_MEM,
    output logic [4:0]          Rd3_MEM,
    output logic [DATA_W-1:0]   WBdata_out,
    output logic                wb_valid,
    output logic                misalign_err,
    output logic                bus_err
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t state, state_nxt;
    logic [7:0] cnt;

    logic              lat_we;
    logic              lat_rw;
    logic [1:0]        lat_size;
    logic              lat_uns;
    logic [1:0]        lat_wbsel;
    logic [DATA_W-1:0] lat_d;
    logic [DATA_W-1:0] lat_alu;
    logic [DATA_W-1:0] lat_npc;
    logic [4:0]        lat_rd;

    logic                is_mem;
    logic                misal;
    logic                start_acc;
    logic                timed_out;
    logic [DATA_W/8-1:0] lane_be;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   wb_idle_val;
    logic [DATA_W-1:0]   wb_done_val;

    assign is_mem    = memR | memW;
    assign misal     = is_misaligned(mem_size, ALUout[1:0]);
    assign start_acc = in_valid & is_mem & ~misal;
    assign timed_out = (cnt == TO_CNT);

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane (
        .size        (lat_size),
        .offset      (lat_alu[1:0]),
        .is_unsigned (lat_uns),
        .store_data  (lat_d),
        .load_raw    (mem_rdata),
        .be          (lane_be),
        .wdata       (lane_wdata),
        .load_ext    (load_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ack takes priority over the timeout when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = BUSY;
            BUSY:    if (mem_ack || timed_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        mem_addr  = '0;
        stall_out = 1'b0;
        case (state)
            IDLE: stall_out = start_acc;
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_be    = lane_be;
                mem_wdata = lane_wdata;
                mem_addr  = lat_alu[ADDR_W+1:2];
                stall_out = ~(mem_ack | timed_out);
            end
            default: ;
        endcase
        stall_out = stall_out & reset;
    end

    always_comb begin
        case (WBdata)
            WB_ALU:  wb_idle_val = ALUout;
            WB_NPC:  wb_idle_val = NPC3;
            default: wb_idle_val = '0;
        endcase
        case (lat_wbsel)
            WB_ALU:  wb_done_val = lat_alu;
            WB_MEM:  wb_done_val = load_ext;
            WB_NPC:  wb_done_val = lat_npc;
            default: wb_done_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_rw    <= 1'b0;
            lat_size  <= '0;
            lat_uns   <= 1'b0;
            lat_wbsel <= '0;
            lat_d     <= '0;
            lat_alu   <= '0;
            lat_npc   <= '0;
            lat_rd    <= '0;
        end else if (state == IDLE) begin
            if (start_acc) begin
                cnt       <= '0;
                lat_we    <= memW;
                lat_rw    <= RegWrite_EX;
                lat_size  <= mem_size;
                lat_uns   <= mem_unsigned;
                lat_wbsel <= WBdata;
                lat_d     <= D;
                lat_alu   <= ALUout;
                lat_npc   <= NPC3;
                lat_rd    <= rd3;
            end
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // MEM/WB register: bubbles clear only the valid/write-enable bits; data holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            RegWrite_MEM <= 1'b0;
            Rd3_MEM      <= '0;
            WBdata_out   <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            RegWrite_MEM <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && (!is_mem || misal)) begin
                    wb_valid     <= 1'b1;
                    RegWrite_MEM <= RegWrite_EX & ~is_mem;
                    Rd3_MEM      <= rd3;
                    WBdata_out   <= wb_idle_val;
                    misalign_err <= is_mem;
                end
            end else if (mem_ack) begin
                wb_valid     <= 1'b1;
                RegWrite_MEM <= lat_rw & ~lat_we;
                Rd3_MEM      <= lat_rd;
                WBdata_out   <= wb_done_val;
            end else if (timed_out) begin
                wb_valid   <= 1'b1;
                Rd3_MEM    <= lat_rd;
                WBdata_out <= '0;
                bus_err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage against a behavioural lane/extension model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, RegWrite_EX, memW, memR, mem_unsigned, mem_ack;
    logic [1:0]  mem_size, WBdata;
    logic [31:0] D, ALUout, NPC3, mem_rdata;
    logic [4:0]  rd3;
    logic        stall_out, mem_req, mem_we, RegWrite_MEM, wb_valid, misalign_err, bus_err;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, WBdata_out;
    logic [4:0]  Rd3_MEM;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W  (32),
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .RegWrite_EX  (RegWrite_EX),
        .memW         (memW),
        .memR         (memR),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .WBdata       (WBdata),
        .D            (D),
        .ALUout       (ALUout),
        .NPC3         (NPC3),
        .rd3          (rd3),
        .stall_out    (stall_out),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .RegWrite_MEM (RegWrite_MEM),
        .Rd3_MEM      (Rd3_MEM),
        .WBdata_out   (WBdata_out),
        .wb_valid     (wb_valid),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = size_bytes(size);
        return 4'(((1 << n) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        int n;
        n = size_bytes(size);
        if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        int n;
        logic [63:0] v, lim;
        n   = size_bytes(size);
        lim = 64'd1 << (8 * n);
        v   = (64'(rdata) >> (8 * addr[1:0])) % lim;
        if (!uns && n < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; RegWrite_EX = 1'b0; memW = 1'b0; memR = 1'b0;
        mem_size = 2'd0; mem_unsigned = 1'b0; WBdata = 2'd0; D = '0;
        ALUout = '0; NPC3 = '0; rd3 = '0; mem_rdata = '0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_valid, RegWrite_MEM, misalign_err, bus_err, mem_req, mem_we, stall_out} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000", {wb_valid, RegWrite_MEM, misalign_err, bus_err, mem_req, mem_we, stall_out});
        end
        checks++;
        if ({Rd3_MEM, WBdata_out, mem_be, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: rd=%h wb=%h be=%h addr=%h wdata=%h required all 0", Rd3_MEM, WBdata_out, mem_be, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic alu_op(input logic [1:0] wbsel, input logic [31:0] alu, input logic [31:0] npc,
                          input logic [4:0] rd, input logic rw, input string name);
        logic [31:0] exp_wb;
        in_valid = 1'b1; memR = 1'b0; memW = 1'b0; WBdata = wbsel;
        ALUout = alu; NPC3 = npc; rd3 = rd; RegWrite_EX = rw; D = $urandom;
        #1;
        checks++;
        if ({stall_out, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL %s stall: stall_out=%b mem_req=%b required 0 0", name, stall_out, mem_req);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_wb = (wbsel == 2'b00) ? alu : (wbsel == 2'b10) ? npc : 32'h0;
        checks++;
        if ({wb_valid, RegWrite_MEM, Rd3_MEM} !== {1'b1, rw, rd}) begin
            errors++;
            $display("FAIL %s ctrl: valid/rw/rd=%b/%b/%0d required 1/%b/%0d", name, wb_valid, RegWrite_MEM, Rd3_MEM, rw, rd);
        end
        checks++;
        if (WBdata_out !== exp_wb) begin
            errors++;
            $display("FAIL %s data: WBdata_out=%h required %h", name, WBdata_out, exp_wb);
        end
    endtask

    task automatic test_alu();
        alu_op(2'b00, 32'h1234, 32'hDEAD, 5'd5, 1'b1, "alu_spec");
        for (int i = 0; i < 8; i++)
            alu_op(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom), 1'($urandom), "alu_rand");
    endtask

    task automatic test_bubble();
        in_valid = 1'b0; RegWrite_EX = 1'b1; memR = 1'b1; ALUout = 32'h40; rd3 = 5'd3;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL bubble_stall: stall_out=%b required 0", stall_out);
        end
        @(posedge clk); #1;
        memR = 1'b0;
        checks++;
        if ({wb_valid, RegWrite_MEM, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL bubble: valid/rw/req=%b required 000", {wb_valid, RegWrite_MEM, mem_req});
        end
    endtask

    task automatic do_access(input logic st, input logic [1:0] size, input logic uns,
                             input logic [1:0] wbsel, input logic [31:0] addr, input logic [31:0] d,
                             input logic [31:0] rdata, input int waits, input logic [4:0] rd,
                             input logic rw, input string name);
        logic [31:0] npc, exp_wb;
        int stalls;
        npc = $urandom;
        in_valid = 1'b1; memW = st; memR = !st; mem_size = size; mem_unsigned = uns;
        WBdata = wbsel; D = d; ALUout = addr; NPC3 = npc; rd3 = rd; RegWrite_EX = rw;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        stalls = 0;
        checks++;
        if (stall_out !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s start: stall_out=%b mem_req=%b required 1 0", name, stall_out, mem_req);
        end
        if (stall_out === 1'b1) stalls++;
        @(posedge clk); #1;
        for (int w = 0; w <= waits; w++) begin
            mem_ack = (w == waits);
            mem_rdata = (w == waits) ? rdata : 32'($urandom);
            #1;
            checks++;
            if ({mem_req, mem_we} !== {1'b1, st}) begin
                errors++;
                $display("FAIL %s req: req/we=%b%b required 1%b", name, mem_req, mem_we, st);
            end
            checks++;
            if (mem_be !== model_be(size, addr) || mem_addr !== addr[17:2]) begin
                errors++;
                $display("FAIL %s be_addr: be=%b addr=%h required %b %h", name, mem_be, mem_addr, model_be(size, addr), addr[17:2]);
            end
            if (st) begin
                checks++;
                if (mem_wdata !== model_wdata(size, d)) begin
                    errors++;
                    $display("FAIL %s wdata: %h required %h", name, mem_wdata, model_wdata(size, d));
                end
            end
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_bubble: wb_valid=%b required 0", name, wb_valid);
            end
            if (stall_out === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; memR = 1'b0; memW = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (stalls !== waits + 1) begin
            errors++;
            $display("FAIL %s stall_cycles: %0d required %0d", name, stalls, waits + 1);
        end
        checks++;
        if ({wb_valid, RegWrite_MEM, Rd3_MEM} !== {1'b1, rw & ~st, rd}) begin
            errors++;
            $display("FAIL %s wb_ctrl: valid/rw/rd=%b/%b/%0d required 1/%b/%0d", name, wb_valid, RegWrite_MEM, Rd3_MEM, rw & ~st, rd);
        end
        if (!st) begin
            exp_wb = (wbsel == 2'b00) ? addr : (wbsel == 2'b01) ? model_load(size, uns, addr, rdata) :
                     (wbsel == 2'b10) ? npc : 32'h0;
            checks++;
            if (WBdata_out !== exp_wb) begin
                errors++;
                $display("FAIL %s load_data: WBdata_out=%h required %h", name, WBdata_out, exp_wb);
            end
        end
        checks++;
        if ({misalign_err, bus_err, mem_req, stall_out} !== 4'b0) begin
            errors++;
            $display("FAIL %s after: mis/bus/req/stall=%b required 0000", name, {misalign_err, bus_err, mem_req, stall_out});
        end
    endtask

    task automatic test_load();
        do_access(1'b0, 2'b00, 1'b0, 2'b01, 32'h0003, 32'h0, 32'h80FF_FF00, 3, 5'd4, 1'b1, "load_byte_signed");
        do_access(1'b0, 2'b00, 1'b1, 2'b01, 32'h0003, 32'h0, 32'h80FF_FF00, 3, 5'd4, 1'b1, "load_byte_unsigned");
        checks++;
        if (WBdata_out !== 32'h0000_0080) begin
            errors++;
            $display("FAIL load_byte_unsigned_const: %h required 00000080", WBdata_out);
        end
        do_access(1'b0, 2'b01, 1'b0, 2'b01, 32'h0102, 32'h0, 32'h9876_1234, 1, 5'd6, 1'b1, "load_half_signed");
    endtask

    task automatic test_store();
        do_access(1'b1, 2'b01, 1'b0, 2'b00, 32'h0002, 32'h0000_ABCD, 32'h0, 0, 5'd8, 1'b1, "store_half");
        checks++;
        if (WBdata_out === 32'hx || RegWrite_MEM !== 1'b0) begin
            errors++;
            $display("FAIL store_half_rw: RegWrite_MEM=%b required 0", RegWrite_MEM);
        end
    endtask

    task automatic misalign_op(input logic st, input logic [1:0] size, input logic [31:0] addr, input string name);
        in_valid = 1'b1; memW = st; memR = !st; mem_size = size; ALUout = addr;
        RegWrite_EX = 1'b1; rd3 = 5'd9; WBdata = 2'b01;
        #1;
        checks++;
        if ({stall_out, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL %s stall: stall/req=%b%b required 00", name, stall_out, mem_req);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; memR = 1'b0; memW = 1'b0;
        checks++;
        if ({misalign_err, wb_valid, RegWrite_MEM, mem_req, bus_err} !== 5'b11000) begin
            errors++;
            $display("FAIL %s flags: mis/valid/rw/req/bus=%b required 11000", name, {misalign_err, wb_valid, RegWrite_MEM, mem_req, bus_err});
        end
        @(posedge clk); #1;
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: misalign_err=%b required 0", name, misalign_err);
        end
    endtask

    task automatic test_misalign_cases();
        misalign_op(1'b0, 2'b10, 32'h0006, "mis_word_load");
        misalign_op(1'b1, 2'b01, 32'h0011, "mis_half_store");
        misalign_op(1'b0, 2'b11, 32'h0021, "mis_reserved_size");
        misalign_op(1'b1, 2'b10, 32'h0003, "mis_word_store");
    endtask

    task automatic test_random_access();
        logic [1:0] size;
        logic [31:0] addr;
        for (int i = 0; i < 12; i++) begin
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            if (size == 2'b01) addr[0] = 1'b0;
            if (size[1]) addr[1:0] = 2'b00;
            do_access(1'($urandom), size, 1'($urandom), 2'($urandom_range(0, 3)), addr, $urandom,
                      $urandom, $urandom_range(0, 6), 5'($urandom), 1'($urandom), "rand_access");
        end
    endtask

    task automatic test_ack_at_limit();
        do_access(1'b0, 2'b10, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 15, 5'd12, 1'b1, "ack_at_timeout");
    endtask

    task automatic test_timeout();
        int n;
        logic done;
        in_valid = 1'b1; memR = 1'b1; memW = 1'b0; mem_size = 2'b10; ALUout = 32'h10;
        WBdata = 2'b01; RegWrite_EX = 1'b1; rd3 = 5'd2; mem_ack = 1'b0;
        #1;
        n = 0; done = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req === 1'b1) n++;
            if (stall_out !== 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; memR = 1'b0;
        #1;
        checks++;
        if (n !== 16 || done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_req_cycles: %0d (ended=%b) required 16 (ended=1)", n, done);
        end
        checks++;
        if ({bus_err, wb_valid, RegWrite_MEM, mem_req, stall_out} !== 5'b11000) begin
            errors++;
            $display("FAIL timeout_flags: bus/valid/rw/req/stall=%b required 11000", {bus_err, wb_valid, RegWrite_MEM, mem_req, stall_out});
        end
        @(posedge clk); #1;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: bus_err=%b required 0", bus_err);
        end
        alu_op(2'b00, 32'h5555_0001, 32'h0, 5'd1, 1'b1, "alu_after_timeout");
    endtask

    task automatic test_idle_ack();
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        alu_op(2'b10, 32'h0, 32'h0000_4444, 5'd10, 1'b1, "idle_ack");
        checks++;
        if ({mem_req, bus_err, misalign_err} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ack_flags: req/bus/mis=%b required 000", {mem_req, bus_err, misalign_err});
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_busy();
        alu_op(2'b00, 32'h0BAD_BEEF, 32'h0, 5'd7, 1'b1, "alu_before_reset");
        in_valid = 1'b1; memR = 1'b1; mem_size = 2'b10; ALUout = 32'h80; WBdata = 2'b01; rd3 = 5'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_pre: mem_req=%b required 1", mem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall_out, wb_valid, RegWrite_MEM, mem_we} !== 5'b0 ||
            {Rd3_MEM, WBdata_out, mem_be, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_busy: req=%b stall=%b valid=%b rw=%b rd=%h wb=%h be=%b addr=%h required all 0",
                     mem_req, stall_out, wb_valid, RegWrite_MEM, Rd3_MEM, WBdata_out, mem_be, mem_addr);
        end
        in_valid = 1'b0; memR = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 2'b00, 1'b0, 2'b01, 32'h0041, 32'h0, 32'h1234_8856, 2, 5'd11, 1'b1, "access_after_reset");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bubble();
        test_load();
        test_store();
        test_misalign_cases();
        test_random_access();
        test_ack_at_limit();
        test_timeout();
        test_idle_ack();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
